cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter.sv | 135 +++++++++++++
 tb/tb_cdb_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one small FIFO per functional unit, drained round-robin
// onto NUM_CDB registered broadcast lanes each cycle.
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int NUM_CDB    = 2,
  parameter int BIT_WIDTH  = 32,
  parameter int TAG_WIDTH  = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_FU-1:0]                   fu_valid,
  input  logic [NUM_FU-1:0][TAG_WIDTH-1:0]    fu_tag,
  input  logic [NUM_FU-1:0][BIT_WIDTH-1:0]    fu_value,
  output logic [NUM_FU-1:0]                   fu_ready,
  output logic [NUM_CDB-1:0][TAG_WIDTH-1:0]   funcUnitTags,
  output logic [NUM_CDB-1:0][BIT_WIDTH-1:0]   funcUnitOut,
  output logic [NUM_CDB-1:0]                  valueReady
);

  localparam int FU_W   = $clog2(NUM_FU);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LANE_W = $clog2(NUM_CDB + 1);

  logic [NUM_FU-1:0][CNT_W-1:0]  count;
  logic [NUM_FU-1:0][PTR_W-1:0]  head;
  logic [NUM_FU-1:0][PTR_W-1:0]  tail;
  logic [TAG_WIDTH-1:0]          tag_mem [NUM_FU][FIFO_DEPTH];
  logic [BIT_WIDTH-1:0]          val_mem [NUM_FU][FIFO_DEPTH];
  logic [FU_W-1:0]               rr;
  logic [FU_W-1:0]               rr_next;

  logic [NUM_FU-1:0]             push;
  logic [NUM_FU-1:0]             grant;
  logic [NUM_FU-1:0][LANE_W-1:0] pos;
  logic [LANE_W-1:0]             n_grant;
  logic [FU_W-1:0]               idx;
  logic [FU_W-1:0]               last_fu;

  logic [NUM_CDB-1:0]                lane_vld_d;
  logic [NUM_CDB-1:0][TAG_WIDTH-1:0] lane_tag_d;
  logic [NUM_CDB-1:0][BIT_WIDTH-1:0] lane_val_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Ready depends on the current count only; a same-cycle pop never frees a slot.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = (count[i] < CNT_W'(FIFO_DEPTH));
    end
  end

  assign push = fu_valid & fu_ready;

  // Scan from rr, granting the first NUM_CDB non-empty FIFOs; pos records lane order.
  always_comb begin
    grant   = '0;
    pos     = '0;
    n_grant = '0;
    idx     = '0;
    last_fu = rr;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = FU_W'((int'(rr) + k) % NUM_FU);
      if ((count[idx] != '0) && (n_grant < LANE_W'(NUM_CDB))) begin
        grant[idx] = 1'b1;
        pos[idx]   = n_grant;
        last_fu    = idx;
        n_grant    = n_grant + LANE_W'(1);
      end
    end
  end

  always_comb begin
    rr_next = rr;
    if (|grant) begin
      rr_next = (last_fu == FU_W'(NUM_FU - 1)) ? '0 : last_fu + FU_W'(1);
    end
  end

  always_comb begin
    lane_vld_d = '0;
    lane_tag_d = '0;
    lane_val_d = '0;
    for (int j = 0; j < NUM_CDB; j++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (grant[i] && (pos[i] == LANE_W'(j))) begin
          lane_vld_d[j] = 1'b1;
          lane_tag_d[j] = tag_mem[i][head[i]];
          lane_val_d[j] = val_mem[i][head[i]];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      head         <= '0;
      tail         <= '0;
      rr           <= '0;
      valueReady   <= '0;
      funcUnitTags <= '0;
      funcUnitOut  <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) tail[i] <= ptr_inc(tail[i]);
        if (grant[i]) head[i] <= ptr_inc(head[i]);
        if (push[i] && !grant[i]) begin
          count[i] <= count[i] + CNT_W'(1);
        end else if (!push[i] && grant[i]) begin
          count[i] <= count[i] - CNT_W'(1);
        end
      end
      rr           <= rr_next;
      valueReady   <= lane_vld_d;
      funcUnitTags <= lane_tag_d;
      funcUnitOut  <= lane_val_d;
    end
  end

  // Storage needs no reset: an entry is only read once count says it was written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        tag_mem[i][tail[i]] <= fu_tag[i];
        val_mem[i][tail[i]] <= fu_value[i];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus a random soak, all checked
// against a queue-based reference model of the FIFOs and round-robin scan.
module tb_cdb_arbiter;

  localparam int NF = 4;
  localparam int NC = 2;
  localparam int BW = 32;
  localparam int TW = 8;
  localparam int FD = 2;

  logic                   clk;
  logic                   reset;
  logic [NF-1:0]          fu_valid;
  logic [NF-1:0][TW-1:0]  fu_tag;
  logic [NF-1:0][BW-1:0]  fu_value;
  logic [NF-1:0]          fu_ready;
  logic [NC-1:0][TW-1:0]  funcUnitTags;
  logic [NC-1:0][BW-1:0]  funcUnitOut;
  logic [NC-1:0]          valueReady;

  cdb_arbiter #(
    .NUM_FU(NF), .NUM_CDB(NC), .BIT_WIDTH(BW), .TAG_WIDTH(TW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_value(fu_value), .fu_ready(fu_ready),
    .funcUnitTags(funcUnitTags), .funcUnitOut(funcUnitOut), .valueReady(valueReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [TW+BW-1:0] q [NF][$];
  int rr_m = 0;
  logic [NC-1:0]         exp_vld;
  logic [NC-1:0][TW-1:0] exp_tag;
  logic [NC-1:0][BW-1:0] exp_val;

  bit soak_on = 1'b0;
  int pend  [NF];
  int waitc [NF];

  task automatic chk_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, then check the registered bus.
  task automatic step(input logic [NF-1:0] v, input logic [NF-1:0][TW-1:0] t,
                      input logic [NF-1:0][BW-1:0] d, output logic [NF-1:0] acc);
    int sz [NF];
    int g  [NF];
    int n;
    int last;
    int fi;
    logic [NF-1:0] elig;
    logic [NF-1:0] obs_acc;
    fu_valid = v;
    fu_tag   = t;
    fu_value = d;
    for (int i = 0; i < NF; i++) begin
      sz[i] = q[i].size();
      chk_eq("fu_ready", 64'(fu_ready[i]), 64'(sz[i] < FD));
      elig[i] = (pend[i] > 0);
    end
    obs_acc = v & fu_ready;
    exp_vld = '0;
    exp_tag = '0;
    exp_val = '0;
    n = 0;
    last = -1;
    for (int k = 0; k < NF; k++) begin
      fi = (rr_m + k) % NF;
      if (sz[fi] > 0 && n < NC) begin
        {exp_tag[n], exp_val[n]} = q[fi].pop_front();
        exp_vld[n] = 1'b1;
        n++;
        last = fi;
      end
    end
    if (n > 0) rr_m = (last + 1) % NF;
    acc = '0;
    for (int i = 0; i < NF; i++) begin
      if (v[i] && sz[i] < FD) begin
        q[i].push_back({t[i], d[i]});
        acc[i] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int j = 0; j < NC; j++) begin
      chk_eq("lane_valid", 64'(valueReady[j]), 64'(exp_vld[j]));
      chk_eq("lane_tag",   64'(funcUnitTags[j]), 64'(exp_tag[j]));
      chk_eq("lane_value", 64'(funcUnitOut[j]), 64'(exp_val[j]));
    end
    if (soak_on) begin
      for (int i = 0; i < NF; i++) g[i] = 0;
      for (int j = 0; j < NC; j++) begin
        if (valueReady[j]) g[funcUnitTags[j][7:6]]++;
      end
      for (int i = 0; i < NF; i++) begin
        if (elig[i] && g[i] == 0) waitc[i]++;
        else waitc[i] = 0;
        chk_eq("starve_wait", 64'(waitc[i] > 1), 64'd0);
        pend[i] += int'(obs_acc[i]) - g[i];
      end
    end
  endtask

  task automatic do_reset();
    fu_valid = '1;
    fu_tag   = {NF{8'hA5}};
    fu_value = {NF{32'h12345678}};
    #2;
    reset = 1'b1;
    #1;
    chk_eq("rst_valid", 64'(valueReady), 64'd0);
    chk_eq("rst_ready", 64'(fu_ready), 64'hF);
    chk_eq("rst_tags",  64'(funcUnitTags), 64'd0);
    chk_eq("rst_out",   64'(funcUnitOut), 64'd0);
    @(posedge clk);
    #1;
    chk_eq("rst_hold_ready", 64'(fu_ready), 64'hF);
    chk_eq("rst_hold_valid", 64'(valueReady), 64'd0);
    #2;
    reset = 1'b0;
    fu_valid = '0;
    for (int i = 0; i < NF; i++) begin
      q[i].delete();
      pend[i]  = 0;
      waitc[i] = 0;
    end
    rr_m = 0;
  endtask

  logic [NF-1:0]         acc;
  logic [NF-1:0][TW-1:0] t;
  logic [NF-1:0][BW-1:0] d;
  int seq [NF];
  int cnt0;

  initial begin
    reset    = 1'b1;
    fu_valid = '0;
    fu_tag   = '0;
    fu_value = '0;
    for (int i = 0; i < NF; i++) begin
      pend[i] = 0; waitc[i] = 0; seq[i] = 0;
    end
    #12;
    chk_eq("init_valid", 64'(valueReady), 64'd0);
    chk_eq("init_ready", 64'(fu_ready), 64'hF);
    reset = 1'b0;

    // Single result from FU2, then FU0+FU3 to expose rr=3 ordering.
    t = '0; d = '0;
    t[2] = 8'h15; d[2] = 32'hDEADBEEF;
    step(4'b0100, t, d, acc);
    chk_eq("single_early", 64'(valueReady), 64'd0);
    step('0, t, d, acc);
    chk_eq("single_vr",  64'(valueReady), 64'b01);
    chk_eq("single_tag", 64'(funcUnitTags[0]), 64'h15);
    chk_eq("single_val", 64'(funcUnitOut[0]), 64'hDEADBEEF);
    step('0, t, d, acc);
    t = '0; t[0] = 8'h30; t[3] = 8'h33;
    step(4'b1001, t, d, acc);
    step('0, t, d, acc);
    chk_eq("rr3_lane0", 64'(funcUnitTags[0]), 64'h33);
    chk_eq("rr3_lane1", 64'(funcUnitTags[1]), 64'h30);

    // Contention: all four push at once from rr=0.
    do_reset();
    for (int i = 0; i < NF; i++) begin
      t[i] = TW'(i + 1); d[i] = BW'(32'h100 + i);
    end
    step('1, t, d, acc);
    step('0, t, d, acc);
    chk_eq("cont_first",  64'(funcUnitTags), 64'h0201);
    step('0, t, d, acc);
    chk_eq("cont_second", 64'(funcUnitTags), 64'h0403);
    step('0, t, d, acc);
    chk_eq("cont_idle", 64'(valueReady), 64'd0);

    // Fill/backpressure: FU0 holds 10,11,12 while FU1..3 keep the lanes busy.
    do_reset();
    cnt0 = 0;
    for (int c = 0; c < 14; c++) begin
      for (int i = 1; i < NF; i++) begin
        t[i] = TW'($urandom_range(8'h40, 8'hFF)); d[i] = $urandom;
      end
      t[0] = TW'(10 + cnt0); d[0] = BW'(32'hF00 + cnt0);
      step({3'b111, cnt0 < 3}, t, d, acc);
      if (acc[0]) cnt0++;
    end
    chk_eq("fill_accepts", 64'(cnt0), 64'd3);

    // Reset with entries pending, then confirm nothing leaks out afterwards.
    for (int i = 0; i < NF; i++) begin
      t[i] = TW'(8'h50 + i); d[i] = $urandom;
    end
    step('1, t, d, acc);
    step('1, t, d, acc);
    do_reset();
    for (int c = 0; c < 3; c++) begin
      step('0, t, d, acc);
      chk_eq("post_rst_idle", 64'(valueReady), 64'd0);
    end

    // Random soak with the FU index encoded in the tag's top bits.
    do_reset();
    soak_on = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NF; i++) begin
        t[i] = {2'(i), 6'(seq[i])};
        d[i] = $urandom;
      end
      step(NF'($urandom), t, d, acc);
      for (int i = 0; i < NF; i++) if (acc[i]) seq[i]++;
    end
    for (int c = 0; c < 4; c++) step('0, t, d, acc);
    for (int i = 0; i < NF; i++) chk_eq("drained", 64'(pend[i]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
